pipe_field_gen: RTL and testbench
=================================

Name: pipe_field_gen

Overview:
Generates the scrolling obstacle field: N_PIPES independent pipes, each with an x position and a gap-centre y. All pipes move left together at a programmable speed on a shared step timebase. When a pipe leaves the left edge it wraps to the back of the field with a new pseudo-random gap. Feeds the pipe renderer and the collision/score logic; sits between the game FSM (run/restart/speed) and the VGA draw path.

Parameters:
N_PIPES, 3, number of pipes (1..8)
X_W, 11, width of each x and y field
SCREEN_W, 640, x of pipe 0 at reset/restart
SPACING, 240, x distance between consecutive pipes; N_PIPES*SPACING+SCREEN_W must be < 2**X_W
STEP_TICKS, 500000, clocks per movement step (>=1)
GAP_MIN, 120, smallest gap-centre y
GAP_MAX, 360, largest gap-centre y (GAP_MAX >= GAP_MIN)
GAP_BITS, 8, LFSR bits used for the gap offset
PLAYER_X, 100, x threshold for score pulses
SEED, 16'hACE1, LFSR reset value (non-zero)

Ports:
clk_100MHz  in  1  system clock
reset  in  1  asynchronous, active-high reset
run  in  1  1 = step counter advances; 0 = field frozen
restart  in  1  synchronous reload of positions/gaps (LFSR untouched)
speed  in  3  pixels moved per step (0 = no motion, pulses still fire)
x_bar  out  N_PIPES*X_W  pipe i x at bits [i*X_W +: X_W]
y_gap  out  N_PIPES*X_W  pipe i gap centre, same packing
step_pulse  out  1  one-cycle pulse on each movement step
respawn  out  N_PIPES  one-cycle pulse, bit i = pipe i wrapped this step
score_pulse  out  N_PIPES  one-cycle pulse, bit i = pipe i crossed PLAYER_X this step

Behaviour:
- Reset (async) values: x[i] = SCREEN_W + i*SPACING; y[i] = (GAP_MIN+GAP_MAX)/2; tick counter 0; LFSR = SEED; all pulses 0.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Shifts every clock after reset, independent of run/restart.
- Tick counter: increments while run=1. At STEP_TICKS-1 it returns to 0 and the step fires in that same cycle. Holds its value while run=0.
- On a step:
  - Per pipe: if x >= speed then x' = x - speed; else x' = x + N_PIPES*SPACING - speed, respawn[i]=1, and y' is taken from the LFSR.
  - Wrapping preserves spacing exactly.
- New gap for pipe i: r = bits [GAP_BITS-1:0] of the LFSR rotated left by 3*i; y' = GAP_MIN + r, saturated to GAP_MAX.
- score_pulse[i] = 1 when x >= PLAYER_X and x' < PLAYER_X on a non-wrap step.
- step_pulse, respawn and score_pulse are registered. They are high for exactly the one cycle after the step cycle, aligned with the updated x_bar/y_gap.
- restart=1 (sync): x, y and the tick counter reload their reset values; pulses are forced to 0; the LFSR continues. restart overrides a coincident step.
- run falling mid-count: the counter freezes. On the next run=1 it resumes from the held count; no step is lost or duplicated.
- Async reset asserted mid-step: all state returns to reset values immediately; no pulses are emitted.
- Outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- Bench params N_PIPES=3, SCREEN_W=20, SPACING=10, STEP_TICKS=4, PLAYER_X=15, GAP_MIN=100, GAP_MAX=150, GAP_BITS=6.
- Reset release -> x={20,30,40}, y={125,125,125}; hold run=1, speed=1 -> step_pulse every 4 clocks; after 1 step x={19,29,39}.
- Pipe 0 at x=0, speed=1 step -> x0'=29, respawn=3'b001, y0 in [100,150]; clamp case r=63 -> y=150.
- speed=3 with pipe 0 at x=2 -> x0'=29 (2+30-3); pipe 0 moving 16->15 at speed=1 -> no score; 15->14 -> score_pulse[0] for one cycle.
- run dropped at count 2 for 10 clocks -> no movement; after run=1 the next step arrives 2 clocks later (count 2->3 completes it).
- restart asserted on a step cycle -> x={20,30,40}, y=125, no pulses; the LFSR value differs from SEED.
- speed=0 -> step_pulse still toggles, x unchanged, no respawn or score pulses.

Source files
------------

// File: rtl/pipe_field_gen.sv
// Scrolling obstacle field: N_PIPES pipes stepping left on a shared tick timebase,
// wrapping to the back of the field with a fresh LFSR-derived gap centre.
module pipe_field_gen #(
    parameter int          N_PIPES    = 3,
    parameter int          X_W        = 11,
    parameter int          SCREEN_W   = 640,
    parameter int          SPACING    = 240,
    parameter int          STEP_TICKS = 500000,
    parameter int          GAP_MIN    = 120,
    parameter int          GAP_MAX    = 360,
    parameter int          GAP_BITS   = 8,
    parameter int          PLAYER_X   = 100,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic                     clk_100MHz,
    input  logic                     reset,
    input  logic                     run,
    input  logic                     restart,
    input  logic [2:0]               speed,
    output logic [N_PIPES*X_W-1:0]   x_bar,
    output logic [N_PIPES*X_W-1:0]   y_gap,
    output logic                     step_pulse,
    output logic [N_PIPES-1:0]       respawn,
    output logic [N_PIPES-1:0]       score_pulse
);

    localparam int               CNT_W     = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(STEP_TICKS - 1);
    localparam logic [X_W-1:0]   WRAP_ADD  = X_W'(N_PIPES * SPACING);
    localparam logic [X_W-1:0]   Y_RST     = X_W'((GAP_MIN + GAP_MAX) / 2);
    localparam logic [X_W-1:0]   GAP_MAX_X = X_W'(GAP_MAX);
    localparam logic [X_W:0]     GAP_MAX_W = (X_W+1)'(GAP_MAX);
    localparam logic [X_W:0]     GAP_MIN_W = (X_W+1)'(GAP_MIN);
    localparam logic [X_W-1:0]   PLAYER_XX = X_W'(PLAYER_X);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic             step_pulse_q;
    logic             step;
    logic [X_W-1:0]   speed_ext;

    assign speed_ext = {{(X_W-3){1'b0}}, speed};

    always_comb begin
        step   = run && (cnt_q == CNT_LAST);
        cnt_d  = cnt_q;
        if (restart || step) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        // Fibonacci taps 16,14,13,11 (bit indices 15,13,12,10)
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            cnt_q        <= '0;
            lfsr_q       <= SEED;
            step_pulse_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            lfsr_q       <= lfsr_d;
            step_pulse_q <= step && !restart;
        end
    end

    assign step_pulse = step_pulse_q;

    genvar gi, gj;
    generate
        for (gi = 0; gi < N_PIPES; gi++) begin : g_pipe
            localparam int             ROT   = (3 * gi) % 16;
            localparam logic [X_W-1:0] X_RST = X_W'(SCREEN_W + gi * SPACING);

            logic [X_W-1:0]      x_q, x_d, y_q, y_d;
            logic [GAP_BITS-1:0] r;
            logic [X_W:0]        gap_sum;
            logic                wrap, score;
            logic                resp_q, score_q;

            // r = low GAP_BITS of the LFSR rotated left by 3*gi
            for (gj = 0; gj < GAP_BITS; gj++) begin : g_rot
                assign r[gj] = lfsr_q[(gj + 16 - ROT) % 16];
            end

            always_comb begin
                wrap    = (x_q < speed_ext);
                gap_sum = GAP_MIN_W + (X_W+1)'(r);
                x_d     = wrap ? (x_q + WRAP_ADD - speed_ext) : (x_q - speed_ext);
                y_d     = y_q;
                if (wrap) begin
                    y_d = (gap_sum > GAP_MAX_W) ? GAP_MAX_X : gap_sum[X_W-1:0];
                end
                score   = !wrap && (x_q >= PLAYER_XX) && (x_d < PLAYER_XX);
            end

            always_ff @(posedge clk_100MHz or posedge reset) begin
                if (reset) begin
                    x_q     <= X_RST;
                    y_q     <= Y_RST;
                    resp_q  <= 1'b0;
                    score_q <= 1'b0;
                end else if (restart) begin
                    x_q     <= X_RST;
                    y_q     <= Y_RST;
                    resp_q  <= 1'b0;
                    score_q <= 1'b0;
                end else begin
                    resp_q  <= step && wrap;
                    score_q <= step && score;
                    if (step) begin
                        x_q <= x_d;
                        y_q <= y_d;
                    end
                end
            end

            assign x_bar[gi*X_W +: X_W] = x_q;
            assign y_gap[gi*X_W +: X_W] = y_q;
            assign respawn[gi]          = resp_q;
            assign score_pulse[gi]      = score_q;
        end
    endgenerate

endmodule

// File: tb/tb_pipe_field_gen.sv
// Randomised and directed bench for pipe_field_gen against a behavioural field model.
module tb_pipe_field_gen;
    localparam int NP = 3;
    localparam int XW = 11;

    logic              clk = 1'b0;
    logic              reset, run, restart;
    logic [2:0]        speed;
    logic [NP*XW-1:0]  x_bar, y_gap;
    logic              step_pulse;
    logic [NP-1:0]     respawn, score_pulse;

    always #5 clk = ~clk;

    pipe_field_gen #(
        .N_PIPES(3), .X_W(11), .SCREEN_W(20), .SPACING(10), .STEP_TICKS(4),
        .GAP_MIN(100), .GAP_MAX(150), .GAP_BITS(6), .PLAYER_X(15), .SEED(16'hACE1)
    ) dut (
        .clk_100MHz(clk), .reset(reset), .run(run), .restart(restart), .speed(speed),
        .x_bar(x_bar), .y_gap(y_gap), .step_pulse(step_pulse),
        .respawn(respawn), .score_pulse(score_pulse)
    );

    int total = 0;
    int bad   = 0;
    int clamps = 0;
    bit cmp_en = 1'b0;

    // behavioural model state
    int            mx[NP];
    int            my[NP];
    int            mcnt;
    logic [15:0]   ml;
    bit            mstep;
    logic [NP-1:0] mresp, mscore;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int gap_of(input logic [15:0] l, input int i);
        int v, k, rot, y;
        v   = int'(l);
        k   = (3 * i) % 16;
        rot = ((v << k) | (v >> (16 - k))) & 32'hFFFF;
        y   = 100 + (rot % 64);
        return (y > 150) ? 150 : y;
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    task automatic model_home();
        for (int i = 0; i < NP; i++) begin
            mx[i] = 20 + 10 * i;
            my[i] = 125;
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            model_home();
            mcnt = 0; ml = 16'hACE1; mstep = 0; mresp = '0; mscore = '0;
        end else begin
            mstep = 0; mresp = '0; mscore = '0;
            if (restart) begin
                model_home();
                mcnt = 0;
            end else begin
                if (run) begin
                    if (mcnt == 3) begin
                        mstep = 1;
                        mcnt  = 0;
                    end else begin
                        mcnt++;
                    end
                end
                if (mstep) begin
                    for (int i = 0; i < NP; i++) begin
                        if (mx[i] >= int'(speed)) begin
                            if (mx[i] >= 15 && mx[i] - int'(speed) < 15) mscore[i] = 1'b1;
                            mx[i] = mx[i] - int'(speed);
                        end else begin
                            mx[i]    = mx[i] + 30 - int'(speed);
                            mresp[i] = 1'b1;
                            my[i]    = gap_of(ml, i);
                        end
                    end
                end
            end
            ml = lfsr_step(ml);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            logic [63:0] ex, ey;
            ex = '0; ey = '0;
            for (int i = 0; i < NP; i++) begin
                ex[i*XW +: XW] = XW'(mx[i]);
                ey[i*XW +: XW] = XW'(my[i]);
                if (mresp[i] && my[i] == 150) clamps++;
            end
            check("x_bar", 64'(x_bar), ex);
            check("y_gap", 64'(y_gap), ey);
            check("step_pulse", 64'(step_pulse), 64'(mstep));
            check("respawn", 64'(respawn), 64'(mresp));
            check("score_pulse", 64'(score_pulse), 64'(mscore));
            if (step_pulse)
                $display("step t=%0t x=%h y=%h respawn=%b score=%b", $time, x_bar, y_gap, respawn, score_pulse);
        end
    end

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic wait_step(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!step_pulse && n < 50);
        if (!step_pulse) check("step_timeout", 64'd0, 64'd1);
    endtask

    function automatic int xo(input int i);
        return int'(x_bar[i*XW +: XW]);
    endfunction

    function automatic int yo(input int i);
        return int'(y_gap[i*XW +: XW]);
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, guard;
        bit seen;
        reset = 1'b1; run = 1'b0; restart = 1'b0; speed = 3'd1;
        repeat (3) tick();
        cmp_en = 1'b1;
        check("rst_x", 64'(x_bar), 64'({11'd40, 11'd30, 11'd20}));
        check("rst_y", 64'(y_gap), 64'({3{11'd125}}));
        check("rst_pulses", 64'({step_pulse, respawn, score_pulse}), 64'd0);

        reset = 1'b0; run = 1'b1;
        wait_step(n);
        check("first_step_latency", 64'(n), 64'd4);
        check("first_step_x", 64'(x_bar), 64'({11'd39, 11'd29, 11'd19}));
        wait_step(n);
        check("step_period", 64'(n), 64'd4);

        guard = 0;
        while (xo(0) != 0 && guard < 40) begin wait_step(n); guard++; end
        wait_step(n);
        check("wrap_x0", 64'(xo(0)), 64'd29);
        check("wrap_respawn", 64'(respawn), 64'b001);
        check("wrap_y0_range", 64'(yo(0) >= 100 && yo(0) <= 150), 64'd1);

        guard = 0;
        while (xo(0) != 16 && guard < 40) begin wait_step(n); guard++; end
        wait_step(n);
        check("x16to15_x", 64'(xo(0)), 64'd15);
        check("x16to15_noscore", 64'(score_pulse[0]), 64'd0);
        wait_step(n);
        check("x15to14_x", 64'(xo(0)), 64'd14);
        check("x15to14_score", 64'(score_pulse[0]), 64'd1);
        tick();
        check("score_one_cycle", 64'(score_pulse[0]), 64'd0);

        guard = 0;
        while (xo(0) != 2 && guard < 40) begin wait_step(n); guard++; end
        speed = 3'd3;
        wait_step(n);
        check("speed3_wrap_x0", 64'(xo(0)), 64'd29);
        check("speed3_respawn0", 64'(respawn[0]), 64'd1);
        speed = 3'd1;

        tick(); tick();
        run = 1'b0;
        seen = 1'b0;
        repeat (10) begin tick(); if (step_pulse) seen = 1'b1; end
        check("frozen_x0", 64'(xo(0)), 64'd29);
        check("frozen_no_pulse", 64'(seen), 64'd0);
        run = 1'b1;
        wait_step(n);
        check("resume_latency", 64'(n), 64'd2);
        check("resume_x0", 64'(xo(0)), 64'd28);

        tick(); tick(); tick();
        restart = 1'b1;
        tick();
        check("restart_x", 64'(x_bar), 64'({11'd40, 11'd30, 11'd20}));
        check("restart_y", 64'(y_gap), 64'({3{11'd125}}));
        check("restart_pulses", 64'({step_pulse, respawn, score_pulse}), 64'd0);
        restart = 1'b0;
        wait_step(n);
        check("post_restart_latency", 64'(n), 64'd4);
        check("post_restart_x", 64'(x_bar), 64'({11'd39, 11'd29, 11'd19}));

        speed = 3'd0;
        repeat (3) begin
            wait_step(n);
            check("speed0_x", 64'(x_bar), 64'({11'd39, 11'd29, 11'd19}));
            check("speed0_quiet", 64'({respawn, score_pulse}), 64'd0);
        end

        speed = 3'd1;
        wait_step(n);
        reset = 1'b1;
        #1;
        check("async_rst_x", 64'(x_bar), 64'({11'd40, 11'd30, 11'd20}));
        check("async_rst_pulses", 64'({step_pulse, respawn, score_pulse}), 64'd0);
        tick();
        reset = 1'b0;

        repeat (3000) begin
            tick();
            run     = ($urandom % 8) != 0;
            speed   = 3'($urandom % 8);
            restart = ($urandom % 64) == 0;
            if ($urandom % 400 == 0) begin
                #1 reset = 1'b1;
                tick();
                reset = 1'b0;
            end
        end
        run = 1'b0; restart = 1'b0;
        tick();
        $display("info: clamped gaps seen=%0d", clamps);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
